// File: rtl/inst_queue_pkg.sv
// Shared defaults and helpers for the decoded-instruction queue.
package inst_queue_pkg;

    localparam int IQ_WIDTH_DEF = 64;
    localparam int IQ_DEPTH_DEF = 8;
    localparam int IQ_LANES_DEF = 2;

    // Bit offset of a lane's payload inside a packed multi-lane bus.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/inst_queue_lane_prefix.sv
// Per-lane accept mask and storage offsets for a contiguous prefix of enqueue lanes.
module lane_prefix
    import inst_queue_pkg::*;
#(
    parameter int LANES = IQ_LANES_DEF,
    parameter int DEPTH = IQ_DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic [LANES-1:0]    i_enq_valid,
    input  logic [CW-1:0]       i_free,
    input  logic                i_bypass_consume,
    input  logic                i_block,
    output logic [LANES-1:0]    o_accept,
    output logic [LANES-1:0]    o_written,
    output logic [LANES*AW-1:0] o_offset,
    output logic [CW-1:0]       o_n_written
);

    logic w_run;

    always_comb begin
        w_run       = ~i_block;
        o_accept    = '0;
        o_written   = '0;
        o_offset    = '0;
        o_n_written = '0;
        for (int i = 0; i < LANES; i++) begin
            // A gap or an exhausted slot budget stops every younger lane.
            w_run = w_run & i_enq_valid[i] & (CW'(i + 1) <= i_free);
            o_accept[i] = w_run;
            if (w_run && !(i == 0 && i_bypass_consume)) begin
                o_written[i]            = 1'b1;
                o_offset[i*AW +: AW]    = AW'(i) - AW'(i_bypass_consume);
                o_n_written             = o_n_written + CW'(1);
            end
        end
    end

endmodule

// File: rtl/inst_queue.sv
// Multi-lane decoded-instruction queue: circular buffer with empty-queue bypass and flush/refill.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int WIDTH = IQ_WIDTH_DEF,
    parameter int DEPTH = IQ_DEPTH_DEF,
    parameter int LANES = IQ_LANES_DEF,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES-1:0]       enq_valid,
    input  logic [LANES*WIDTH-1:0] enq_data,
    output logic [LANES-1:0]       enq_accept,
    output logic                   deq_valid,
    output logic [WIDTH-1:0]       deq_data,
    input  logic                   deq_ready,
    input  logic                   flush,
    input  logic                   flush_load,
    input  logic [WIDTH-1:0]       flush_data,
    output logic [CW-1:0]          count,
    output logic                   full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_head;
    logic [CW-1:0]    r_count;
    logic             r_full;

    logic             w_empty;
    logic             w_bypass;
    logic             w_fire;
    logic             w_bypass_consume;
    logic [CW-1:0]    w_free;
    logic [CW-1:0]    w_cnt_after;
    logic [CW-1:0]    w_count_next;
    logic [AW-1:0]    w_head_next;
    logic [AW-1:0]    w_base;
    logic [LANES-1:0] w_written;
    logic [LANES*AW-1:0] w_offset;
    logic [CW-1:0]    w_n_written;

    assign w_empty          = (r_count == '0);
    assign w_bypass         = w_empty & enq_valid[0];
    assign deq_valid        = ~w_empty | enq_valid[0];
    assign deq_data         = w_bypass ? enq_data[0 +: WIDTH] :
                              (w_empty ? '0 : r_mem[r_head]);
    assign w_fire           = deq_valid & deq_ready;
    assign w_bypass_consume = w_bypass & deq_ready;

    assign w_free       = CW'(DEPTH) - r_count + CW'(w_fire);
    // A consumed bypass lane never occupied a slot, so only stored entries leave the count.
    assign w_cnt_after  = r_count - CW'(w_fire & ~w_empty);
    assign w_head_next  = r_head + AW'(w_fire);
    assign w_base       = w_head_next + w_cnt_after[AW-1:0];
    assign w_count_next = w_cnt_after + w_n_written;

    lane_prefix #(
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) u_lane_prefix (
        .i_enq_valid      (enq_valid),
        .i_free           (w_free),
        .i_bypass_consume (w_bypass_consume),
        .i_block          (flush | rst),
        .o_accept         (enq_accept),
        .o_written        (w_written),
        .o_offset         (w_offset),
        .o_n_written      (w_n_written)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else if (flush) begin
            r_count <= flush_load ? CW'(1) : '0;
            r_full  <= 1'b0;
        end else begin
            r_head  <= w_head_next;
            r_count <= w_count_next;
            r_full  <= (w_count_next == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (flush) begin
                if (flush_load)
                    r_mem[r_head] <= flush_data;
            end else begin
                for (int i = 0; i < LANES; i++) begin
                    if (w_written[i])
                        r_mem[w_base + w_offset[i*AW +: AW]] <= enq_data[lane_lsb(i, WIDTH) +: WIDTH];
                end
            end
        end
    end

    assign count = r_count;
    assign full  = r_full;

endmodule
